// File: rtl/ram64_arbiter.sv
// Clear sequencer and round-robin A/B arbiter driving the single address/write
// port of a 64-deep distributed RAM (synchronous write, asynchronous read).
module ram64_arbiter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] CLR_VAL  = '0,
  parameter bit               CLEAR_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR_REQ,
  input  logic             A_REQ,
  input  logic             A_WE,
  input  logic [5:0]       A_ADR,
  input  logic [WIDTH-1:0] A_DIN,
  output logic             A_GNT,
  output logic             A_RVALID,
  output logic [WIDTH-1:0] A_DOUT,
  input  logic             B_REQ,
  input  logic             B_WE,
  input  logic [5:0]       B_ADR,
  input  logic [WIDTH-1:0] B_DIN,
  output logic             B_GNT,
  output logic             B_RVALID,
  output logic [WIDTH-1:0] B_DOUT,
  output logic [5:0]       RAM_ADR,
  output logic             RAM_WE,
  output logic [WIDTH-1:0] RAM_DIN,
  input  logic [WIDTH-1:0] RAM_DOUT,
  output logic             BUSY
);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic [WIDTH-1:0] a_dout_q, a_dout_d;
  logic [WIDTH-1:0] b_dout_q, b_dout_d;
  logic             run;
  logic             a_gnt, b_gnt;

  // last_q = 1 means B was granted most recently, so A wins a tie
  always_comb begin
    run   = (state_q == S_RUN);
    a_gnt = run && A_REQ && (!B_REQ || last_q);
    b_gnt = run && B_REQ && (!A_REQ || !last_q);
  end

  always_comb begin
    RAM_ADR = '0;
    RAM_WE  = 1'b0;
    RAM_DIN = '0;
    if (!run) begin
      RAM_ADR = cnt_q;
      RAM_WE  = 1'b1;
      RAM_DIN = CLR_VAL;
    end else if (a_gnt) begin
      RAM_ADR = A_ADR;
      RAM_WE  = A_WE;
      RAM_DIN = A_DIN;
    end else if (b_gnt) begin
      RAM_ADR = B_ADR;
      RAM_WE  = B_WE;
      RAM_DIN = B_DIN;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    a_rvalid_d = a_gnt && !A_WE;
    b_rvalid_d = b_gnt && !B_WE;
    a_dout_d   = a_rvalid_d ? RAM_DOUT : a_dout_q;
    b_dout_d   = b_rvalid_d ? RAM_DOUT : b_dout_q;
    if (state_q == S_CLEAR) begin
      // counter wraps 63 -> 0 on its own, leaving it at 0 for the next clear
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd63) state_d = S_RUN;
    end else begin
      if (CLEAR_REQ) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
      if (a_gnt)      last_d = 1'b0;
      else if (b_gnt) last_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= CLEAR_EN ? S_CLEAR : S_RUN;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
    end
  end

  always_comb begin
    A_GNT    = a_gnt;
    B_GNT    = b_gnt;
    A_RVALID = a_rvalid_q;
    B_RVALID = b_rvalid_q;
    A_DOUT   = a_dout_q;
    B_DOUT   = b_dout_q;
    BUSY     = !run;
  end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ram64_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_req;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_adr, b_adr;
  logic [7:0] a_din, b_din;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we, busy;
  logic [7:0] a_dout, b_dout, ram_din, ram_dout;
  logic [5:0] ram_adr;

  logic       c_a_req, c_a_we;
  logic [5:0] c_a_adr;
  logic [7:0] c_a_din;
  logic       c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid, c_ram_we, c_busy;
  logic [7:0] c_a_dout, c_b_dout, c_ram_din, c_ram_dout;
  logic [5:0] c_ram_adr;

  logic [7:0] ram1 [64];
  logic [7:0] ram2 [64];

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] CLR = 8'hA5;

  always #5 clk = ~clk;

  ram64_arbiter #(.WIDTH(8), .CLR_VAL(CLR), .CLEAR_EN(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .CLEAR_REQ(clear_req),
    .A_REQ(a_req), .A_WE(a_we), .A_ADR(a_adr), .A_DIN(a_din),
    .A_GNT(a_gnt), .A_RVALID(a_rvalid), .A_DOUT(a_dout),
    .B_REQ(b_req), .B_WE(b_we), .B_ADR(b_adr), .B_DIN(b_din),
    .B_GNT(b_gnt), .B_RVALID(b_rvalid), .B_DOUT(b_dout),
    .RAM_ADR(ram_adr), .RAM_WE(ram_we), .RAM_DIN(ram_din),
    .RAM_DOUT(ram_dout), .BUSY(busy)
  );

  ram64_arbiter #(.WIDTH(8), .CLR_VAL(CLR), .CLEAR_EN(1'b0)) dut_nc (
    .CLK(clk), .RST_N(rst_n), .CLEAR_REQ(1'b0),
    .A_REQ(c_a_req), .A_WE(c_a_we), .A_ADR(c_a_adr), .A_DIN(c_a_din),
    .A_GNT(c_a_gnt), .A_RVALID(c_a_rvalid), .A_DOUT(c_a_dout),
    .B_REQ(1'b0), .B_WE(1'b0), .B_ADR(6'd0), .B_DIN(8'd0),
    .B_GNT(c_b_gnt), .B_RVALID(c_b_rvalid), .B_DOUT(c_b_dout),
    .RAM_ADR(c_ram_adr), .RAM_WE(c_ram_we), .RAM_DIN(c_ram_din),
    .RAM_DOUT(c_ram_dout), .BUSY(c_busy)
  );

  always @(posedge clk) if (ram_we) ram1[ram_adr] <= ram_din;
  assign ram_dout = ram1[ram_adr];
  always @(posedge clk) if (c_ram_we) ram2[c_ram_adr] <= c_ram_din;
  assign c_ram_dout = ram2[c_ram_adr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, clear progress, who was served last,
  // and the read results each requester must show in the coming cycle.
  logic [7:0] m_mem [64];
  bit         m_clr = 1'b1;
  int         m_idx = 0;
  bit         m_prev_b = 1'b1;
  bit         m_arv = 1'b0, m_brv = 1'b0;
  logic [7:0] m_adout = '0, m_bdout = '0;

  initial for (int i = 0; i < 64; i++) m_mem[i] = '0;

  always @(negedge clk) begin : model
    bit         ea, eb, ewe;
    logic [5:0] eadr;
    logic [7:0] edin;
    if (!rst_n) begin
      m_clr = 1'b1; m_idx = 0; m_prev_b = 1'b1;
      m_arv = 1'b0; m_brv = 1'b0; m_adout = '0; m_bdout = '0;
      m_mem[0] = CLR;
    end
    ea = 1'b0; eb = 1'b0;
    if (!m_clr) begin
      if (a_req && b_req) begin
        if (m_prev_b) ea = 1'b1; else eb = 1'b1;
      end else begin
        ea = a_req; eb = b_req;
      end
    end
    if (m_clr)   begin ewe = 1'b1; eadr = 6'(m_idx); edin = CLR; end
    else if (ea) begin ewe = a_we; eadr = a_adr;     edin = a_din; end
    else if (eb) begin ewe = b_we; eadr = b_adr;     edin = b_din; end
    else         begin ewe = 1'b0; eadr = '0;        edin = '0; end

    chk("m_busy", busy, m_clr);
    chk("m_a_gnt", a_gnt, ea);
    chk("m_b_gnt", b_gnt, eb);
    chk("m_ram_we", ram_we, ewe);
    chk("m_ram_adr", ram_adr, eadr);
    chk("m_ram_din", ram_din, edin);
    chk("m_a_rvalid", a_rvalid, m_arv);
    chk("m_b_rvalid", b_rvalid, m_brv);
    chk("m_a_dout", a_dout, m_adout);
    chk("m_b_dout", b_dout, m_bdout);

    if (rst_n) begin
      m_arv = 1'b0; m_brv = 1'b0;
      if (m_clr) begin
        m_mem[m_idx] = CLR;
        if (m_idx == 63) begin m_clr = 1'b0; m_idx = 0; end
        else m_idx++;
      end else begin
        if (ea) begin
          m_prev_b = 1'b0;
          if (a_we) m_mem[a_adr] = a_din;
          else begin m_arv = 1'b1; m_adout = m_mem[a_adr]; end
        end else if (eb) begin
          m_prev_b = 1'b1;
          if (b_we) m_mem[b_adr] = b_din;
          else begin m_brv = 1'b1; m_bdout = m_mem[b_adr]; end
        end
        if (clear_req) begin m_clr = 1'b1; m_idx = 0; end
      end
    end
  end

  // CLEAR_EN = 0 instance: no clear, immediate service after reset
  initial begin
    c_a_req = 1'b0; c_a_we = 1'b0; c_a_adr = '0; c_a_din = '0;
    @(posedge rst_n);
    c_a_req = 1'b1; c_a_we = 1'b1; c_a_adr = 6'd2; c_a_din = 8'h5A;
    @(negedge clk);
    chk("nc_busy_low", c_busy, 1'b0);
    chk("nc_gnt_write", c_a_gnt, 1'b1);
    @(posedge clk); #1 c_a_we = 1'b0;
    @(negedge clk);
    chk("nc_gnt_read", c_a_gnt, 1'b1);
    @(posedge clk); #1 c_a_req = 1'b0;
    @(negedge clk);
    chk("nc_rvalid", c_a_rvalid, 1'b1);
    chk("nc_dout", c_a_dout, 8'h5A);
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    logic ga, gb;
    rst_n = 1'b0; clear_req = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_adr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_adr = '0; b_din = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_adr = 6'd17;
    @(negedge clk);
    chk("busy_after_reset", busy, 1'b1);
    chk("clear_first_adr", ram_adr, 6'd0);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("clear_len_reset", n, 64);
    chk("a_gnt_first_run", a_gnt, 1'b1);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk);
    chk("a_rvalid_adr17", a_rvalid, 1'b1);
    chk("a_dout_adr17", a_dout, CLR);

    // write then read back next cycle
    @(posedge clk); #1 a_req = 1'b1; a_we = 1'b1; a_adr = 6'd5; a_din = 8'h3C;
    @(negedge clk); chk("a_gnt_wr5", a_gnt, 1'b1);
    @(posedge clk); #1 a_we = 1'b0;
    @(negedge clk); chk("a_gnt_rd5", a_gnt, 1'b1);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk);
    chk("a_rvalid_rd5", a_rvalid, 1'b1);
    chk("a_dout_rd5", a_dout, 8'h3C);

    // B alone writes 9, leaving A with priority for the next tie
    @(posedge clk); #1 b_req = 1'b1; b_we = 1'b1; b_adr = 6'd9; b_din = 8'h11;
    @(negedge clk); chk("b_gnt_wr9", b_gnt, 1'b1);
    @(posedge clk); #1 a_req = 1'b1; a_we = 1'b1; a_adr = 6'd40; a_din = 8'h77;
    b_we = 1'b0; b_adr = 6'd40;
    @(negedge clk);
    chk("cont_a_first", a_gnt, 1'b1);
    chk("cont_b_waits", b_gnt, 1'b0);
    @(posedge clk); #1 a_req = 1'b0;
    @(negedge clk); chk("cont_b_next", b_gnt, 1'b1);
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk);
    chk("cont_b_rvalid", b_rvalid, 1'b1);
    chk("cont_b_dout", b_dout, 8'h77);

    // clear request in the same cycle as a B read grant
    @(posedge clk); #1 b_req = 1'b1; b_we = 1'b0; b_adr = 6'd9; clear_req = 1'b1;
    @(negedge clk); chk("clrreq_b_gnt", b_gnt, 1'b1);
    @(posedge clk); #1 b_req = 1'b0; clear_req = 1'b0;
    @(negedge clk);
    chk("clrreq_b_rvalid", b_rvalid, 1'b1);
    chk("clrreq_b_dout", b_dout, 8'h11);
    chk("clrreq_busy", busy, 1'b1);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("clear_len_req", n, 64);
    @(posedge clk); #1 b_req = 1'b1;
    @(negedge clk); chk("b_gnt_rd9", b_gnt, 1'b1);
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk); chk("b_dout_cleared9", b_dout, CLR);

    // reset in the middle of a clear at address 30
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); chk("mid_clear_adr30", ram_adr, 6'd30);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b1);
    chk("rst_ram_adr", ram_adr, 6'd0);
    chk("rst_a_dout", a_dout, 8'h00);
    chk("rst_b_dout", b_dout, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_adr = 6'd3;
    b_req = 1'b1; b_we = 1'b0; b_adr = 6'd4;
    @(negedge clk);
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk("clear_len_restart", n, 64);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("rr_a_gnt", a_gnt, (i % 2) == 0);
      chk("rr_b_gnt", b_gnt, (i % 2) == 1);
    end
    @(posedge clk); #1 b_req = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("a_alone_gnt", a_gnt, 1'b1);
    end
    @(posedge clk); #1 a_req = 1'b0;

    // randomized traffic obeying the hold-until-granted handshake
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk); ga = a_gnt; gb = b_gnt;
      @(posedge clk); #1;
      if (ga || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we  = 1'($urandom_range(0, 1));
        a_adr = 6'($urandom_range(0, 15));
        a_din = 8'($urandom_range(0, 255));
      end
      if (gb || !b_req) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_we  = 1'($urandom_range(0, 1));
        b_adr = 6'($urandom_range(0, 15));
        b_din = 8'($urandom_range(0, 255));
      end
      clear_req = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); ga = a_gnt; gb = b_gnt;
    @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0; clear_req = 1'b0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
